// File: rtl/dadda_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dadda_pkg
// Purpose  : Shared widths, FSM encoding and carry-save helpers for the
//            tiled 32x32 Dadda multiplier.
// Revision : 1.0 - initial release
// ============================================================================
package dadda_pkg;

  localparam int TILE_W         = 8;
  localparam int N_TILES_PER_OP = 4;
  localparam int N_TILES        = 16;
  localparam int OP_W           = 32;
  localparam int PROD_W         = 64;
  localparam int CNT_W          = $clog2(N_TILES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [2*TILE_W-1:0] csaSum(
    input logic [2*TILE_W-1:0] x,
    input logic [2*TILE_W-1:0] y,
    input logic [2*TILE_W-1:0] z
  );
    return x ^ y ^ z;
  endfunction

  function automatic logic [2*TILE_W-1:0] csaCarry(
    input logic [2*TILE_W-1:0] x,
    input logic [2*TILE_W-1:0] y,
    input logic [2*TILE_W-1:0] z
  );
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dadda_8.sv
`default_nettype none
// ============================================================================
// Module   : dadda_8
// Purpose  : Combinational 8x8 unsigned multiplier, Dadda-style reduction of
//            eight partial-product rows through heights 6-4-3-2.
// Revision : 1.0 - initial release
// ============================================================================
import dadda_pkg::*;

module dadda_8 (
  input  logic [TILE_W-1:0]   x,
  input  logic [TILE_W-1:0]   y,
  output logic [2*TILE_W-1:0] prod
);

  logic [2*TILE_W-1:0] w_row [TILE_W];

  generate
    for (genvar g = 0; g < TILE_W; g++) begin : g_pp
      assign w_row[g] = (2*TILE_W)'(x & {TILE_W{y[g]}}) << g;
    end
  endgenerate

  // Truncating to 16 bits is safe: the exact product never exceeds 16 bits.
  logic [2*TILE_W-1:0] w_s1a, w_c1a, w_s1b, w_c1b;
  logic [2*TILE_W-1:0] w_s2a, w_c2a, w_s2b, w_c2b;
  logic [2*TILE_W-1:0] w_s3, w_c3, w_s4, w_c4;

  assign w_s1a = csaSum  (w_row[0], w_row[1], w_row[2]);
  assign w_c1a = csaCarry(w_row[0], w_row[1], w_row[2]);
  assign w_s1b = csaSum  (w_row[3], w_row[4], w_row[5]);
  assign w_c1b = csaCarry(w_row[3], w_row[4], w_row[5]);

  assign w_s2a = csaSum  (w_s1a, w_c1a, w_s1b);
  assign w_c2a = csaCarry(w_s1a, w_c1a, w_s1b);
  assign w_s2b = csaSum  (w_c1b, w_row[6], w_row[7]);
  assign w_c2b = csaCarry(w_c1b, w_row[6], w_row[7]);

  assign w_s3  = csaSum  (w_s2a, w_c2a, w_s2b);
  assign w_c3  = csaCarry(w_s2a, w_c2a, w_s2b);

  assign w_s4  = csaSum  (w_s3, w_c3, w_c2b);
  assign w_c4  = csaCarry(w_s3, w_c3, w_c2b);

  assign prod  = w_s4 + w_c4;

endmodule
`default_nettype wire

// File: rtl/dadda_seq_32.sv
`default_nettype none
// ============================================================================
// Module   : dadda_seq_32
// Purpose  : 32x32 unsigned multiplier iterating 16 byte tiles through one
//            dadda_8. Define DADDA_SEQ_ZERO_SKIP_EN to short-cut zero operands.
// Revision : 1.0 - initial release
// ============================================================================
import dadda_pkg::*;

module dadda_seq_32 (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] p,
  output logic              busy
);

  state_t              r_state;
  logic [OP_W-1:0]     r_opA, r_opB;
  logic [PROD_W-1:0]   r_accumulator, r_product;
  logic [CNT_W-1:0]    r_counter;
  logic                r_inReady, r_outValid, r_busy;

  logic [1:0]          w_i, w_j;
  logic [TILE_W-1:0]   w_aByte, w_bByte;
  logic [2*TILE_W-1:0] w_tileProd;
  logic [5:0]          w_shiftAmt;
  logic [PROD_W-1:0]   w_addend, w_accumNext;

  assign w_i        = r_counter[1:0];
  assign w_j        = r_counter[3:2];
  assign w_aByte    = r_opA[TILE_W*w_i +: TILE_W];
  assign w_bByte    = r_opB[TILE_W*w_j +: TILE_W];
  assign w_shiftAmt = {3'(w_i) + 3'(w_j), 3'b000};
  assign w_addend   = PROD_W'(w_tileProd) << w_shiftAmt;
  assign w_accumNext = r_accumulator + w_addend;

  dadda_8 u_dadda8 (
    .x    (w_aByte),
    .y    (w_bByte),
    .prod (w_tileProd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_opA         <= '0;
      r_opB         <= '0;
      r_accumulator <= '0;
      r_counter     <= '0;
      r_product     <= '0;
      r_inReady     <= 1'b1;
      r_outValid    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_inReady) begin
            r_opA         <= a;
            r_opB         <= b;
            r_accumulator <= '0;
            r_counter     <= '0;
            r_inReady     <= 1'b0;
            r_busy        <= 1'b1;
`ifdef DADDA_SEQ_ZERO_SKIP_EN
            if (a == '0 || b == '0) begin
              r_state    <= DONE;
              r_product  <= '0;
              r_outValid <= 1'b1;
            end else begin
              r_state    <= MUL;
            end
`else
            r_state       <= MUL;
`endif
          end
        end
        MUL: begin
          r_accumulator <= w_accumNext;
          r_counter     <= r_counter + 1'b1;
          if (r_counter == CNT_W'(N_TILES - 1)) begin
            r_product  <= w_accumNext;
            r_state    <= DONE;
            r_outValid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state    <= IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_busy     <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign p         = r_product;

endmodule
`default_nettype wire

// File: tb/tb_dadda_seq_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_dadda_seq_32
// Purpose  : Directed and randomised self-checking bench for dadda_seq_32.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dadda_seq_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] p;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dadda_seq_32 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds in_valid for exactly one edge; the caller ensures in_ready is high.
  task automatic startOp(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges counted from the acceptance edge until out_valid; bounded at 40.
  task automatic waitValid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (p !== 64'h0) begin errors++; $display("FAIL reset_p got %h want 0", p); end
  endtask

  task automatic test_basic();
    int lat;
    startOp(32'd3, 32'd5);
    checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    waitValid(lat);
    checks++; if (lat !== 16) begin errors++; $display("FAIL basic_latency got %0d want 16", lat); end
    checks++; if (p !== 64'h000000000000000F) begin errors++; $display("FAIL basic_p got %h want f", p); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_return got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_corners();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] vp [4];
    int lat;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; vp[0] = 64'hFFFFFFFE00000001;
    va[1] = 32'h00010000; vb[1] = 32'h00010000; vp[1] = 64'h0000000100000000;
    va[2] = 32'h12345678; vb[2] = 32'h00000100; vp[2] = 64'h0000001234567800;
    va[3] = 32'hDEADBEEF; vb[3] = 32'h00000002; vp[3] = 64'h00000001BD5B7DDE;
    for (int k = 0; k < 4; k++) begin
      startOp(va[k], vb[k]);
      waitValid(lat);
      checks++; if (lat !== 16) begin errors++; $display("FAIL corner%0d_latency got %0d want 16", k, lat); end
      checks++; if (p !== vp[k]) begin errors++; $display("FAIL corner%0d_p got %h want %h", k, p, vp[k]); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit spurious;
    out_ready = 1'b0;
    startOp(32'h10, 32'h20);
    waitValid(lat);
    checks++; if (p !== 64'h200) begin errors++; $display("FAIL bp_p got %h want 200", p); end
    a = 32'd99; b = 32'd99; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || p !== 64'h200 || in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d got out_valid=%b p=%h in_ready=%b want 1/200/0", k, out_valid, p, in_ready); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    spurious = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid || busy) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL bp_ignored got activity=%b want 0", spurious); end
  endtask

  task automatic test_reset_mid();
    int lat;
    bit spurious;
    startOp(32'h11111111, 32'h22222222);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || p !== 64'h0) begin errors++; $display("FAIL midrst_outputs got in_ready=%b out_valid=%b busy=%b p=%h want 1/0/0/0", in_ready, out_valid, busy, p); end
    spurious = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (out_valid) spurious = 1'b1;
    end
    checks++; if (spurious !== 1'b0) begin errors++; $display("FAIL midrst_no_valid got %b want 0", spurious); end
    startOp(32'd7, 32'd9);
    waitValid(lat);
    checks++; if (lat !== 16 || p !== 64'd63) begin errors++; $display("FAIL midrst_after got lat=%0d p=%0d want 16/63", lat, p); end
    tick();
  endtask

  task automatic test_operand_change();
    int lat;
    startOp(32'd1000, 32'd1000);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; in_valid = 1'b1;
    waitValid(lat);
    in_valid = 1'b0;
    checks++; if (lat !== 16 || p !== 64'd1000000) begin errors++; $display("FAIL opchange got lat=%0d p=%0d want 16/1000000", lat, p); end
    tick();
  endtask

  task automatic test_zero();
    int lat;
    startOp(32'd0, 32'h1234);
    waitValid(lat);
`ifdef DADDA_SEQ_ZERO_SKIP_EN
    checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got %0d want 0", lat); end
`else
    checks++; if (lat !== 16) begin errors++; $display("FAIL zero_latency got %0d want 16", lat); end
`endif
    checks++; if (p !== 64'h0) begin errors++; $display("FAIL zero_p got %h want 0", p); end
    tick();
  endtask

  task automatic test_random();
    int lat;
    logic [31:0] x, y;
    logic [63:0] expect_p;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      x = $urandom;
      y = $urandom;
      if (n % 7 == 0) x = x & 32'hFF00FF00;
      expect_p = {32'h0, x} * {32'h0, y};
      out_ready = 1'b0;
      startOp(x, y);
      waitValid(lat);
      repeat ($urandom_range(0, 3)) tick();
      checks++; if (out_valid !== 1'b1 || p !== expect_p) begin errors++; $display("FAIL random%0d got valid=%b p=%h want 1/%h", n, out_valid, p, expect_p); end
      out_ready = 1'b1;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_reset_mid();
    test_operand_change();
    test_zero();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
